alu_iterative: RTL and testbench

ALU_ITERATIVE -- requirements
Module: alu_iterative

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_iterative_if.sv | 26 ++
 rtl/alu_slice.sv | 42 ++++
 rtl/alu_iterative.sv | 150 +++++++++++++++
 tb/tb_alu_iterative.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Opcodes, FSM encoding and flag bundle shared by the iterative ALU and its slice.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_NOR = 3'b100,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } flags_t;

  // SUB and SLT run the adder as A + ~B + 1.
  function automatic logic op_binv(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic op_arith(input logic [2:0] op);
    return (op == OP_ADD) || op_binv(op);
  endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Request/response bundle of the iterative ALU; master issues operations, slave computes them.
interface alu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, op, a_in, b_in, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice, zero latency, no flow control.
// Exposes the carry into its top bit so the caller can derive signed overflow.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic             binv,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] bb;
  logic [SLICE-1:0] low;
  logic [SLICE-1:0] sum;

  // Low bits are added separately so the carry into the top bit is visible.
  always_comb begin
    bb    = binv ? ~b : b;
    low   = {1'b0, a[SLICE-2:0]} + {1'b0, bb[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
    c_msb = low[SLICE-1];
    sum   = {a[SLICE-1] ^ bb[SLICE-1] ^ c_msb, low[SLICE-2:0]};
    cout  = (a[SLICE-1] & bb[SLICE-1]) | (c_msb & (a[SLICE-1] ^ bb[SLICE-1]));
  end

  always_comb begin
    y = '0;
    case (op)
      OP_AND:                 y = a & b;
      OP_OR:                  y = a | b;
      OP_NOR:                 y = ~(a | b);
      OP_ADD, OP_SUB, OP_SLT: y = sum;
      default:                y = '0;
    endcase
  end

endmodule

// File: rtl/alu_iterative.sv
// Iterative ALU: one SLICE-bit slice per cycle, result valid N+1 cycles after accept.
// Single operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic            clk,
  input logic            rst_n,
  alu_iterative_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e                 state_q;
  state_e                 state_d;
  logic [2:0]             op_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [WIDTH-1:0]       acc_q;
  logic [WIDTH-1:0]       result_q;
  logic [CW-1:0]          cnt_q;
  logic                   carry_q;
  logic                   c_msb_q;
  logic                   res_vld_q;
  flags_t                 flags_q;

  logic                   accept;
  logic                   slice_en;
  logic                   finish;
  logic                   release_res;
  logic                   last_slice;
  logic                   binv;
  logic [SLICE-1:0]       s_y;
  logic                   s_cout;
  logic                   s_cmsb;
  logic [WIDTH+SLICE-1:0] acc_shift;
  logic [WIDTH-1:0]       fin_result;
  flags_t                 fin_flags;

  assign binv       = op_binv(op_q);
  assign last_slice = (cnt_q == CW'(N - 1));
  assign accept     = bus.in_valid && bus.in_ready;
  assign acc_shift  = {s_y, acc_q};

  // Operands shift down so the active slice is always the low SLICE bits.
  alu_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .cin   (carry_q),
    .binv  (binv),
    .op    (op_q),
    .y     (s_y),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: if (res_vld_q && bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The first DONE cycle folds the last carries into flags; that is the +1 of the latency.
  always_comb begin
    bus.in_ready = 1'b0;
    slice_en     = 1'b0;
    finish       = 1'b0;
    release_res  = 1'b0;
    case (state_q)
      ST_IDLE: bus.in_ready = 1'b1;
      ST_RUN:  slice_en = 1'b1;
      ST_DONE: begin
        finish      = !res_vld_q;
        release_res = res_vld_q && bus.out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.op;
      a_q     <= bus.a_in;
      b_q     <= bus.b_in;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= op_binv(bus.op);
      c_msb_q <= 1'b0;
    end else if (slice_en) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      acc_q   <= acc_shift[WIDTH+SLICE-1:SLICE];
      carry_q <= s_cout;
      c_msb_q <= s_cmsb;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // SLT is "A-B negative" corrected for overflow, i.e. the true signed compare.
  always_comb begin
    fin_flags.cout     = op_arith(op_q) ? carry_q : 1'b0;
    fin_flags.overflow = op_arith(op_q) ? (c_msb_q ^ carry_q) : 1'b0;
    fin_result         = acc_q;
    if (op_q == OP_SLT) begin
      fin_result = {{(WIDTH-1){1'b0}}, acc_q[WIDTH-1] ^ fin_flags.overflow};
    end
    fin_flags.zero = (fin_result == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else if (finish) begin
      res_vld_q <= 1'b1;
      result_q  <= fin_result;
      flags_q   <= fin_flags;
    end else if (release_res) begin
      res_vld_q <= 1'b0;
    end
  end

  assign bus.out_valid = res_vld_q;
  assign bus.result    = result_q;
  assign bus.cout      = flags_q.cout;
  assign bus.overflow  = flags_q.overflow;
  assign bus.zero      = flags_q.zero;

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative at 32/8, 16/4 and 64/16: directed cases plus random ops
// checked every cycle against an arithmetic reference model.
module tb_alu_iterative;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  logic        iv   [3];
  logic        ordy [3];
  logic [2:0]  opd  [3];
  logic [63:0] ad   [3];
  logic [63:0] bd   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        co   [3];
  logic        vf   [3];
  logic        zr   [3];
  logic [63:0] rs   [3];

  alu_iterative_if #(.WIDTH(32)) bus0 ();
  alu_iterative_if #(.WIDTH(16)) bus1 ();
  alu_iterative_if #(.WIDTH(64)) bus2 ();

  alu_iterative #(.WIDTH(32), .SLICE(8))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  alu_iterative #(.WIDTH(16), .SLICE(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_iterative #(.WIDTH(64), .SLICE(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.in_valid = iv[0];  assign bus0.op = opd[0];  assign bus0.out_ready = ordy[0];
  assign bus0.a_in = ad[0][31:0]; assign bus0.b_in = bd[0][31:0];
  assign bus1.in_valid = iv[1];  assign bus1.op = opd[1];  assign bus1.out_ready = ordy[1];
  assign bus1.a_in = ad[1][15:0]; assign bus1.b_in = bd[1][15:0];
  assign bus2.in_valid = iv[2];  assign bus2.op = opd[2];  assign bus2.out_ready = ordy[2];
  assign bus2.a_in = ad[2];       assign bus2.b_in = bd[2];

  assign ir[0] = bus0.in_ready; assign ov[0] = bus0.out_valid; assign rs[0] = {32'd0, bus0.result};
  assign co[0] = bus0.cout;     assign vf[0] = bus0.overflow;  assign zr[0] = bus0.zero;
  assign ir[1] = bus1.in_ready; assign ov[1] = bus1.out_valid; assign rs[1] = {48'd0, bus1.result};
  assign co[1] = bus1.cout;     assign vf[1] = bus1.overflow;  assign zr[1] = bus1.zero;
  assign ir[2] = bus2.in_ready; assign ov[2] = bus2.out_valid; assign rs[2] = bus2.result;
  assign co[2] = bus2.cout;     assign vf[2] = bus2.overflow;  assign zr[2] = bus2.zero;

  function automatic int w_of(input int k);
    return (k == 0) ? 32 : (k == 1) ? 16 : 64;
  endfunction

  function automatic int n_of(input int k);
    return w_of(k) / ((k == 0) ? 8 : (k == 1) ? 4 : 16);
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endfunction

  // Reference: plain w-bit arithmetic on masked operands.
  function automatic void model(input int w, input logic [2:0] op,
                                input logic [63:0] a_raw, input logic [63:0] b_raw,
                                output logic [63:0] r, output logic c, output logic v);
    logic [63:0] m, a, b;
    logic [64:0] s;
    longint      sa, sb;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a = a_raw & m;
    b = b_raw & m;
    r = '0; c = 1'b0; v = 1'b0; s = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: r = ~(a | b) & m;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0] & m;
        c = s[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'b110, 3'b111: begin
        s = {1'b0, a} + {1'b0, ~b & m} + 65'd1;
        r = s[63:0] & m;
        c = s[w];
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
        if (op == 3'b111) begin
          sa = $signed(a << (64 - w)) >>> (64 - w);
          sb = $signed(b << (64 - w)) >>> (64 - w);
          r  = (sa < sb) ? 64'd1 : 64'd0;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [63:0] rnd_opnd(input int w);
    logic [63:0] m;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return m;
      2:       return m >> 1;
      3:       return (m >> 1) + 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // Compare process: follows each instance from accept to handshake.
  initial begin : compare
    logic        busy [3];
    int          cyc  [3];
    logic [63:0] er   [3];
    logic        ec   [3];
    logic        ev   [3];
    logic        want_idle [3];
    for (int k = 0; k < 3; k++) begin
      busy[k] = 1'b0; cyc[k] = 0; er[k] = '0; ec[k] = 1'b0; ev[k] = 1'b0; want_idle[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          busy[k] = 1'b0;
          want_idle[k] = 1'b0;
        end else if (busy[k]) begin
          cyc[k]++;
          chk1($sformatf("in_ready_busy%0d", k), ir[k], 1'b0);
          if (cyc[k] < n_of(k) + 2) begin
            chk1($sformatf("early_valid%0d", k), ov[k], 1'b0);
          end else begin
            chk1($sformatf("valid_latency%0d", k), ov[k], 1'b1);
            chk($sformatf("result%0d", k), rs[k], er[k]);
            chk1($sformatf("cout%0d", k), co[k], ec[k]);
            chk1($sformatf("overflow%0d", k), vf[k], ev[k]);
            chk1($sformatf("zero%0d", k), zr[k], er[k] == 64'd0);
            if (ov[k] && ordy[k]) begin
              busy[k] = 1'b0;
              want_idle[k] = 1'b1;
            end
          end
        end else begin
          chk1($sformatf("idle_valid%0d", k), ov[k], 1'b0);
          if (want_idle[k]) begin
            chk1($sformatf("in_ready_return%0d", k), ir[k], 1'b1);
            want_idle[k] = 1'b0;
          end
          if (iv[k] && ir[k]) begin
            busy[k] = 1'b1;
            cyc[k]  = 0;
            model(w_of(k), opd[k], ad[k], bd[k], er[k], ec[k], ev[k]);
          end
        end
      end
    end
  end

  task automatic do_op(input int k, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input int hold, output int lat,
                       output logic [63:0] r, output logic c, output logic v, output logic z);
    int t;
    t = 0;
    while (!ir[k] && t < 100) begin @(posedge clk); #1; t++; end
    chk1("wait_in_ready", ir[k], 1'b1);
    opd[k] = op; ad[k] = a; bd[k] = b; iv[k] = 1'b1; ordy[k] = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs while the operation runs.
    iv[k] = 1'b0; opd[k] = 3'($urandom_range(0, 7)); ad[k] = {$urandom, $urandom}; bd[k] = {$urandom, $urandom};
    lat = 0;
    while (!ov[k] && lat < 200) begin @(posedge clk); #1; lat++; end
    chk1("wait_out_valid", ov[k], 1'b1);
    r = rs[k]; c = co[k]; v = vf[k]; z = zr[k];
    repeat (hold) begin
      iv[k] = 1'b1;
      @(posedge clk); #1;
    end
    iv[k] = 1'b0; ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          lat;
    logic [63:0] r, mr;
    logic        c, v, z, mc, mv;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; opd[k] = '0; ad[k] = '0; bd[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("rst_in_ready%0d", k), ir[k], 1'b1);
      chk1($sformatf("rst_out_valid%0d", k), ov[k], 1'b0);
      chk($sformatf("rst_result%0d", k), rs[k], 64'd0);
      chk1($sformatf("rst_cout%0d", k), co[k], 1'b0);
      chk1($sformatf("rst_overflow%0d", k), vf[k], 1'b0);
      chk1($sformatf("rst_zero%0d", k), zr[k], 1'b0);
    end
    @(posedge clk); #1;

    model(32, 3'b010, 64'h7FFF_FFFF, 64'h1, mr, mc, mv);
    chk("model_add", mr, 64'h8000_0000);
    chk1("model_add_ovf", mv, 1'b1);
    model(32, 3'b111, 64'hFFFF_FFFF, 64'h1, mr, mc, mv);
    chk("model_slt", mr, 64'd1);
    model(16, 3'b110, 64'h0, 64'h1, mr, mc, mv);
    chk("model_sub16", mr, 64'hFFFF);
    chk1("model_sub16_cout", mc, 1'b0);

    do_op(0, 3'b010, 64'h7FFF_FFFF, 64'h1, 0, lat, r, c, v, z);
    chk("add_lat", 64'(lat), 64'd5);
    chk("add_res", r, 64'h8000_0000);
    chk1("add_ovf", v, 1'b1);
    chk1("add_cout", c, 1'b0);

    do_op(0, 3'b110, 64'h5, 64'h5, 0, lat, r, c, v, z);
    chk("sub_res", r, 64'd0);
    chk1("sub_zero", z, 1'b1);
    chk1("sub_cout", c, 1'b1);
    chk1("sub_ovf", v, 1'b0);

    do_op(0, 3'b111, 64'hFFFF_FFFF, 64'h1, 0, lat, r, c, v, z);
    chk("slt_neg", r, 64'd1);
    do_op(0, 3'b111, 64'h1, 64'hFFFF_FFFF, 0, lat, r, c, v, z);
    chk("slt_swap", r, 64'd0);

    do_op(0, 3'b001, 64'h1234_0000, 64'h0000_5678, 10, lat, r, c, v, z);
    chk("bp_or_res", r, 64'h1234_5678);

    do_op(0, 3'b011, 64'hDEAD_BEEF, 64'h1234_5678, 0, lat, r, c, v, z);
    chk("undef_res", r, 64'd0);
    chk("undef_lat", 64'(lat), 64'd5);

    // Abort an ADD while slice 2 is due.
    opd[0] = 3'b010; ad[0] = 64'h1111_1111; bd[0] = 64'h2222_2222; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk1("abort_in_ready", ir[0], 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk1("abort_no_valid", ov[0], 1'b0);
    end
    do_op(0, 3'b100, 64'h0F0F_0F0F, 64'hF0F0_F0F0, 0, lat, r, c, v, z);
    chk("nor_res", r, 64'd0);
    chk1("nor_zero", z, 1'b1);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        do_op(k, 3'($urandom_range(0, 7)), rnd_opnd(w_of(k)), rnd_opnd(w_of(k)),
              $urandom_range(0, 3), lat, r, c, v, z);
        chk($sformatf("rand_lat%0d", k), 64'(lat), 64'(n_of(k) + 1));
      end
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
